// File: rtl/tl_seq_monitor.sv
// Passive checker for traffic-light lamp outputs: decodes r/y/g, tracks the
// R->Y->G->R sequence and dwell times, and flags encoding/order/timing faults.
module tl_seq_monitor #(
    parameter int unsigned R_CYCLES = 1,
    parameter int unsigned Y_CYCLES = 1,
    parameter int unsigned G_CYCLES = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r,
    input  logic             y,
    input  logic             g,
    output logic [1:0]       phase,
    output logic             err_onehot,
    output logic             err_order,
    output logic             err_dwell,
    output logic             err_sticky,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_RED  = 2'd1;
    localparam logic [1:0] PH_YEL  = 2'd2;
    localparam logic [1:0] PH_GRN  = 2'd3;

    localparam logic [CNT_W-1:0] R_REQ     = CNT_W'(R_CYCLES);
    localparam logic [CNT_W-1:0] Y_REQ     = CNT_W'(Y_CYCLES);
    localparam logic [CNT_W-1:0] G_REQ     = CNT_W'(G_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             onehot_q, onehot_d;
    logic             order_q, order_d;
    logic             dwell_err_q, dwell_err_d;
    logic             sticky_q, sticky_d;

    logic [1:0]       lamp_ph;
    logic             lamp_dark;
    logic             lamp_ill;
    logic [1:0]       succ_ph;
    logic [CNT_W-1:0] req;

    always_comb begin
        lamp_ph   = PH_IDLE;
        lamp_dark = 1'b0;
        lamp_ill  = 1'b0;
        case ({r, y, g})
            3'b100:  lamp_ph   = PH_RED;
            3'b010:  lamp_ph   = PH_YEL;
            3'b001:  lamp_ph   = PH_GRN;
            3'b000:  lamp_dark = 1'b1;
            default: lamp_ill  = 1'b1;
        endcase
    end

    always_comb begin
        succ_ph = (phase_q == PH_GRN) ? PH_RED : phase_q + 2'd1;
        case (phase_q)
            PH_RED:  req = R_REQ;
            PH_YEL:  req = Y_REQ;
            PH_GRN:  req = G_REQ;
            default: req = '0;
        endcase
    end

    always_comb begin
        phase_d     = phase_q;
        dwell_d     = dwell_q;
        cnt_d       = cnt_q;
        onehot_d    = 1'b0;
        order_d     = 1'b0;
        dwell_err_d = 1'b0;
        if (phase_q == PH_IDLE) begin
            if (lamp_ill) begin
                onehot_d = 1'b1;
            end else if (!lamp_dark) begin
                phase_d = lamp_ph;
                dwell_d = ONE;
            end
        end else if (lamp_ill || lamp_dark) begin
            onehot_d = 1'b1;
        end else if (lamp_ph == phase_q) begin
            // Only the first over-long sample flags; later ones see dwell > req.
            dwell_err_d = (dwell_q == req);
            if (dwell_q != DWELL_MAX) dwell_d = dwell_q + ONE;
        end else if (lamp_ph == succ_ph) begin
            dwell_err_d = (dwell_q < req);
            if (phase_q == PH_GRN) cnt_d = cnt_q + ONE;
            phase_d = lamp_ph;
            dwell_d = ONE;
        end else begin
            order_d = 1'b1;
            phase_d = lamp_ph;
            dwell_d = ONE;
        end
        sticky_d = sticky_q | onehot_d | order_d | dwell_err_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= PH_IDLE;
            dwell_q     <= '0;
            cnt_q       <= '0;
            onehot_q    <= 1'b0;
            order_q     <= 1'b0;
            dwell_err_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            onehot_q    <= onehot_d;
            order_q     <= order_d;
            dwell_err_q <= dwell_err_d;
            sticky_q    <= sticky_d;
        end
    end

    assign phase      = phase_q;
    assign err_onehot = onehot_q;
    assign err_order  = order_q;
    assign err_dwell  = dwell_err_q;
    assign err_sticky = sticky_q;
    assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_tl_seq_monitor.sv
// Bench for tl_seq_monitor: directed vector table, multi-cycle corner sequences
// and a randomized run against a phase-rule reference model.
module tb_tl_seq_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r = 1'b0, y = 1'b0, g = 1'b0;

    logic [1:0] phase_a, phase_b;
    logic       e1_a, eo_a, ed_a, st_a;
    logic       e1_b, eo_b, ed_b, st_b;
    logic [7:0] cnt_a;
    logic [2:0] cnt_b;

    int tests  = 0;
    int failed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    tl_seq_monitor dut_a (
        .clk(clk), .rst(rst), .r(r), .y(y), .g(g),
        .phase(phase_a), .err_onehot(e1_a), .err_order(eo_a), .err_dwell(ed_a),
        .err_sticky(st_a), .cycle_cnt(cnt_a)
    );

    tl_seq_monitor #(.R_CYCLES(3), .Y_CYCLES(2), .G_CYCLES(2), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .r(r), .y(y), .g(g),
        .phase(phase_b), .err_onehot(e1_b), .err_order(eo_b), .err_dwell(ed_b),
        .err_sticky(st_b), .cycle_cnt(cnt_b)
    );

    // packed view: {phase, onehot, order, dwell, sticky, cnt[7:0]}
    function automatic logic [31:0] act_a();
        return {18'd0, phase_a, e1_a, eo_a, ed_a, st_a, cnt_a};
    endfunction
    function automatic logic [31:0] act_b();
        return {18'd0, phase_b, e1_b, eo_b, ed_b, st_b, 5'd0, cnt_b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got ph=%0d oh=%0b ord=%0b dw=%0b st=%0b cnt=%0d, expected ph=%0d oh=%0b ord=%0b dw=%0b st=%0b cnt=%0d",
                     name, act[13:12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[13:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    function automatic logic [31:0] pk(input int ph, input bit e1, input bit eo,
                                       input bit ed, input bit st, input int cnt);
        return {18'd0, 2'(ph), e1, eo, ed, st, 8'(cnt)};
    endfunction

    task automatic step(input logic [2:0] rgb);
        {r, y, g} = rgb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {r, y, g} = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference model: phases 1..3 in a ring, successor of p is p%3+1.
    typedef struct {
        int ph; int dw; int cnt; bit st; bit e1; bit eo; bit ed;
    } mstate_t;

    function automatic mstate_t model_step(input mstate_t s, input logic [2:0] rgb,
                                           input int rq, input int yq, input int gq,
                                           input int cntw);
        mstate_t n;
        int lamp;
        int req [4];
        req[0] = 0; req[1] = rq; req[2] = yq; req[3] = gq;
        n = s;
        n.e1 = 0; n.eo = 0; n.ed = 0;
        case (rgb)
            3'b100:  lamp = 1;
            3'b010:  lamp = 2;
            3'b001:  lamp = 3;
            3'b000:  lamp = 0;
            default: lamp = -1;
        endcase
        if (s.ph == 0) begin
            if (lamp < 0) n.e1 = 1;
            else if (lamp > 0) begin n.ph = lamp; n.dw = 1; end
        end else if (lamp <= 0) begin
            n.e1 = 1;
        end else if (lamp == s.ph) begin
            n.ed = (s.dw == req[s.ph]);
            if (s.dw < (1 << cntw) - 1) n.dw = s.dw + 1;
        end else if (lamp == s.ph % 3 + 1) begin
            n.ed = (s.dw < req[s.ph]);
            if (s.ph == 3) n.cnt = (s.cnt + 1) % (1 << cntw);
            n.ph = lamp; n.dw = 1;
        end else begin
            n.eo = 1; n.ph = lamp; n.dw = 1;
        end
        n.st = s.st | n.e1 | n.eo | n.ed;
        return n;
    endfunction

    function automatic logic [31:0] mpk(input mstate_t s);
        return pk(s.ph, s.e1, s.eo, s.ed, s.st, s.cnt);
    endfunction

    typedef struct {
        logic [2:0] rgb;
        int ph; bit e1; bit eo; bit ed; bit st; int cnt;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        mstate_t ma, mb;
        int c;
        logic [2:0] rgb;

        vecs[0]  = '{3'b000, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{3'b100, 1, 0, 0, 0, 0, 0};
        vecs[2]  = '{3'b010, 2, 0, 0, 0, 0, 0};
        vecs[3]  = '{3'b001, 3, 0, 0, 0, 0, 0};
        vecs[4]  = '{3'b100, 1, 0, 0, 0, 0, 1};
        vecs[5]  = '{3'b001, 3, 0, 1, 0, 1, 1};
        vecs[6]  = '{3'b100, 1, 0, 0, 0, 1, 2};
        vecs[7]  = '{3'b110, 1, 1, 0, 0, 1, 2};
        vecs[8]  = '{3'b010, 2, 0, 0, 0, 1, 2};
        vecs[9]  = '{3'b010, 2, 0, 0, 1, 1, 2};
        vecs[10] = '{3'b010, 2, 0, 0, 0, 1, 2};
        vecs[11] = '{3'b000, 2, 1, 0, 0, 1, 2};
        vecs[12] = '{3'b100, 1, 0, 1, 0, 1, 2};
        vecs[13] = '{3'b100, 1, 0, 0, 1, 1, 2};
        vecs[14] = '{3'b100, 1, 0, 0, 0, 1, 2};
        vecs[15] = '{3'b010, 2, 0, 0, 0, 1, 2};

        // reset state, checked while reset is still asserted
        @(posedge clk);
        #1;
        check("reset_a", act_a(), pk(0, 0, 0, 0, 0, 0));
        check("reset_b", act_b(), pk(0, 0, 0, 0, 0, 0));
        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].rgb);
            check($sformatf("vec%0d", i), act_a(),
                  pk(vecs[i].ph, vecs[i].e1, vecs[i].eo, vecs[i].ed, vecs[i].st, vecs[i].cnt));
        end

        // Long red phase too short for a 3-cycle requirement
        do_reset();
        step(3'b100);
        step(3'b100);
        check("short_red_hold", act_b(), pk(1, 0, 0, 0, 0, 0));
        step(3'b010);
        check("short_red_exit", act_b(), pk(2, 0, 0, 1, 1, 0));

        // Asynchronous reset in GRN with errors pending
        do_reset();
        step(3'b100); step(3'b010); step(3'b001); step(3'b100);
        step(3'b001);
        check("pre_async_rst", act_a(), pk(3, 0, 1, 0, 1, 1));
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_a", act_a(), pk(0, 0, 0, 0, 0, 0));
        check("async_rst_b", act_b(), pk(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(3'b100); step(3'b010); step(3'b001); step(3'b100);
        check("resume_round", act_a(), pk(1, 0, 0, 0, 0, 1));

        // Randomized run against the reference model, both parameter sets
        do_reset();
        ma = '{0, 0, 0, 0, 0, 0, 0};
        mb = '{0, 0, 0, 0, 0, 0, 0};
        c = 1;
        for (int k = 0; k < 400; k++) begin
            int pick;
            pick = $urandom_range(0, 19);
            if (pick == 1) c = $urandom_range(1, 3);
            else if (pick >= 2 && pick <= 5) c = c % 3 + 1;
            rgb = (c == 1) ? 3'b100 : (c == 2) ? 3'b010 : 3'b001;
            if (pick == 0) rgb = 3'($urandom_range(0, 7));
            ma = model_step(ma, rgb, 1, 1, 1, 8);
            mb = model_step(mb, rgb, 3, 2, 2, 3);
            exp_q.push_back(mpk(ma));
            exp_q.push_back(mpk(mb));
            step(rgb);
            check($sformatf("rand_a%0d", k), act_a(), exp_q.pop_front());
            check($sformatf("rand_b%0d", k), act_b(), exp_q.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
